conv_window_ctrl: RTL
=====================

Name: conv_window_ctrl

Overview:
- Controller that sequences the pixel delay-line and window register bank, built from nbit_dff instances, feeding the convolution engine.
- Accepts a raster-order pixel stream under a valid/ready handshake and drives the shared shift enable to the register bank.
- Tracks row and column position and flags when the register bank holds a complete KxK window.
- Passes window-valid and output coordinates to the MAC stage, with backpressure, and pulses frame_done at the end of each frame.

Parameters:
- IMG_W, 28, pixels per row (>= K)
- IMG_H, 28, rows per frame (>= K)
- K, 3, convolution kernel size (window is KxK)
- CW, $clog2(IMG_W), column counter width
- RW, $clog2(IMG_H), row counter width

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
- in_valid  in  1  upstream pixel present
- in_ready  out  1  controller can accept a pixel this cycle
- shift_en  out  1  enable to every nbit_dff in the delay-line/window bank
- out_valid  out  1  register bank holds a complete window
- out_ready  in  1  MAC stage consumes the window
- out_row  out  RW  output-map row of the current window
- out_col  out  CW  output-map column of the current window
- busy  out  1  high in RUN or DRAIN
- frame_done  out  1  one-cycle pulse when a frame completes

Behaviour:
- Reset is synchronous: on a clk edge with reset=1 the controller goes to state IDLE, clears the row/col counters, and drives out_valid=0, out_row=0, out_col=0, frame_done=0, busy=0. Reset mid-frame abandons the frame with no frame_done.
- States and transitions:
  - IDLE: start=1 -> RUN; counters cleared.
  - RUN: accepting the pixel at (row=IMG_H-1, col=IMG_W-1) -> DRAIN.
  - DRAIN: wait until out_valid=0, or out_valid & out_ready -> DONE.
  - DONE: frame_done=1 for exactly one cycle -> IDLE.
  - start is ignored outside IDLE.
- Handshake:
  - in_ready = (state==RUN) & ~(out_valid & ~out_ready). This is combinational and stalls input while a window is unconsumed.
  - accept = in_valid & in_ready.
  - shift_en = accept (combinational), so the bank loads the pixel on the same edge.
- Counters:
  - On accept, col increments; at col==IMG_W-1, col wraps to 0 and row increments.
  - row does not advance past IMG_H-1.
- Window detection: a window is complete on accept of pixel (r,c) with r>=K-1 and c>=K-1.
  - On that edge: out_valid<=1, out_row<=r-(K-1), out_col<=c-(K-1).
  - Latency: 1 cycle from the accepting edge to out_valid.
- out_valid holding rules:
  - out_valid holds, with stable out_row/out_col, until out_ready=1.
  - Consume with no new window on the same edge -> out_valid<=0.
  - Consume together with a new window -> out_valid stays 1 with new coordinates, giving back-to-back throughput of 1 window per cycle.
- Border pixels (r<K-1 or c<K-1) shift with no window. The wrap between rows produces no window for the first K-1 columns.
- Window count per frame is exactly (IMG_H-K+1)*(IMG_W-K+1).
- busy = (state==RUN) | (state==DRAIN).
- Simultaneous in_valid and start while in IDLE: the pixel is not accepted that cycle, because in_ready=0 in IDLE.

Decomposition:
- Shared package cnn_ctrl_pkg:
  - state encoding IDLE/RUN/DRAIN/DONE (2-bit)
  - default IMG_W/IMG_H/K constants, shared with the line-buffer and MAC blocks
- One sub-module: raster_counter (col/row counter with enable, wrap at IMG_W-1, last-pixel flag).
- The FSM and out_valid/coordinate register stay in conv_window_ctrl.

Test Plan:
Bench uses IMG_W=4, IMG_H=4, K=3.
- reset held 2 cycles mid-frame -> state IDLE, out_valid=0, in_ready=0, no frame_done; a new start then runs a clean frame.
- start, then 16 pixels with in_valid=1 and out_ready=1 -> shift_en high 16 cycles; out_valid for 4 windows at (0,0),(0,1),(1,0),(1,1); frame_done exactly once, 2 cycles after the last accept.
- out_ready=0 when the first window appears -> in_ready drops and shift_en=0; out_row=0/out_col=0 held; on out_ready=1 the stream resumes with no lost or duplicated window.
- in_valid toggling 1/0 every cycle -> counters advance only on accept; same 4 windows and coordinates as the continuous case.
- start pulsed during RUN -> ignored; counters unaffected; a single frame_done.
- Back-to-back frames, start asserted the cycle after frame_done -> second frame yields 4 windows, counters restart at (0,0).

Source files
------------

// File: rtl/cnn_ctrl_pkg.sv
// Shared definitions for the convolution control path: the window controller
// state encoding and the default image/kernel geometry.
package cnn_ctrl_pkg;

    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;
    localparam int K_DEF     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_t;

    function automatic logic state_busy(input ctrl_state_t st);
        return (st == ST_RUN) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order column/row position counter. The column wraps at IMG_W-1 and the
// row saturates at IMG_H-1; last flags the final pixel position of a frame.
module raster_counter
    import cnn_ctrl_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last
);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_r;
    logic [RW-1:0] row_r;
    logic [CW-1:0] col_nxt_s;
    logic [RW-1:0] row_nxt_s;

    // next position: clear wins over enable, row holds at the bottom edge
    always_comb begin
        col_nxt_s = col_r;
        row_nxt_s = row_r;
        if (clr) begin
            col_nxt_s = '0;
            row_nxt_s = '0;
        end else if (en) begin
            if (col_r == COL_LAST) begin
                col_nxt_s = '0;
                if (row_r == ROW_LAST) begin
                    row_nxt_s = row_r;
                end else begin
                    row_nxt_s = row_r + RW'(1);
                end
            end else begin
                col_nxt_s = col_r + CW'(1);
                row_nxt_s = row_r;
            end
        end else begin
            col_nxt_s = col_r;
            row_nxt_s = row_r;
        end
    end

    // position registers
    always_ff @(posedge clk) begin
        if (reset) begin
            col_r <= '0;
            row_r <= '0;
        end else begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
        end
    end

    assign col  = col_r;
    assign row  = row_r;
    assign last = (col_r == COL_LAST) && (row_r == ROW_LAST);

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequencer for the pixel delay-line / window register bank: gates the shared
// shift enable, tracks raster position and presents complete KxK windows.
module conv_window_ctrl
    import cnn_ctrl_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int K     = K_DEF,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          shift_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          busy,
    output logic          frame_done
);

    localparam logic [CW-1:0] KM1_C = CW'(K - 1);
    localparam logic [RW-1:0] KM1_R = RW'(K - 1);

    ctrl_state_t   state_r;
    ctrl_state_t   state_nxt_s;
    logic          cnt_clr_s;
    logic          accept_s;
    logic          hold_s;
    logic          consume_s;
    logic          win_s;
    logic [CW-1:0] col_s;
    logic [RW-1:0] row_s;
    logic          last_s;
    logic          out_valid_r;
    logic [RW-1:0] out_row_r;
    logic [CW-1:0] out_col_r;
    logic          busy_r;
    logic          frame_done_r;

    raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CW    (CW),
        .RW    (RW)
    ) u_raster_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr_s),
        .en    (accept_s),
        .col   (col_s),
        .row   (row_s),
        .last  (last_s)
    );

    // An unconsumed window blocks input so the bank never overwrites it.
    assign hold_s    = out_valid_r & ~out_ready;
    assign in_ready  = (state_r == ST_RUN) & ~hold_s;
    assign accept_s  = in_valid & in_ready;
    assign shift_en  = accept_s;
    assign consume_s = out_valid_r & out_ready;
    assign win_s     = accept_s & (row_s >= KM1_R) & (col_s >= KM1_C);

    // next-state logic; counters are held clear while idle
    always_comb begin
        state_nxt_s = state_r;
        cnt_clr_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_clr_s = 1'b1;
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && last_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!out_valid_r || out_ready) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // state register with status outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            busy_r       <= state_busy(state_nxt_s);
            frame_done_r <= (state_nxt_s == ST_DONE);
        end
    end

    // window register: a new window replaces a consumed one on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_row_r   <= '0;
            out_col_r   <= '0;
        end else if (win_s) begin
            out_valid_r <= 1'b1;
            out_row_r   <= row_s - KM1_R;
            out_col_r   <= col_s - KM1_C;
        end else if (consume_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_row    = out_row_r;
    assign out_col    = out_col_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule
